// File: rtl/drac_pkg.sv
// Shared types for the data cache request tracker: entry state encoding,
// per-entry control record and cache command codes.
package drac_pkg;

  typedef enum logic [2:0] {
    StFree,
    StPend,
    StIssued,
    StDone,
    StZombie
  } tracker_state_t;

  typedef struct packed {
    tracker_state_t state;
    logic           is_store;
    logic [3:0]     op_type;
    logic [4:0]     rd;
    logic           xcpt;
  } tracker_entry_t;

  localparam logic [4:0] CmdLoad  = 5'b00000;
  localparam logic [4:0] CmdStore = 5'b00001;

  function automatic logic [4:0] cmd_of(input logic is_store);
    return is_store ? CmdStore : CmdLoad;
  endfunction

endpackage

// File: rtl/tracker_oldest_pend.sv
// Rotating priority finder: returns the first set bit of pend_i at or after
// head_i, wrapping modulo DEPTH, i.e. the oldest pending entry.
module tracker_oldest_pend #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] pend_i,
  input  logic [IdxW-1:0]  head_i,
  output logic             found_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = head_i;
    cand    = head_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // DEPTH is a power of two, so the index add wraps naturally.
      cand = head_i + IdxW'(i);
      if (!found_o && pend_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/dcache_req_tracker.sv
// Circular tracker for up to DEPTH outstanding data cache requests: issues
// oldest-first with entry-index tags, replays nacks, retires in program order.
module dcache_req_tracker
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [3:0]        req_op_type_i,
  input  logic [4:0]        req_rd_i,
  input  logic              kill_i,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [4:0]        dmem_req_cmd_o,
  output logic [ADDR_W-1:0] dmem_req_addr_o,
  output logic [DATA_W-1:0] dmem_req_data_o,
  output logic [3:0]        dmem_op_type_o,
  output logic [TAG_W-1:0]  dmem_req_tag_o,
  output logic              dmem_req_kill_o,
  input  logic              dmem_resp_valid_i,
  input  logic              dmem_resp_nack_i,
  input  logic [TAG_W-1:0]  dmem_resp_tag_i,
  input  logic [DATA_W-1:0] dmem_resp_data_i,
  input  logic              dmem_xcpt_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic [4:0]        resp_rd_o,
  output logic              resp_xcpt_o,
  output logic              dmem_is_load_o,
  output logic              dmem_is_store_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  tracker_entry_t    ent_q   [DEPTH];
  tracker_entry_t    ent_d   [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] rdata_q [DEPTH];
  logic [DATA_W-1:0] rdata_d [DEPTH];

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [IdxW-1:0] issue_q, issue_d;
  logic            hold_q, hold_d;
  logic            drain_q, drain_d;
  logic            kill_pulse_q;
  logic            is_load_q, is_store_q;

  logic [DEPTH-1:0] pend_vec;
  logic             pend_found;
  logic [IdxW-1:0]  pend_idx;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_vld;
  logic             alloc, issue_hs, retire;
  logic             tag_ok, resp_hit, nack_hit;
  logic [IdxW-1:0]  resp_idx;
  logic             zombie_any;

  always_comb begin
    pend_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_vec[i] = (ent_q[i].state == StPend);
    end
  end

  tracker_oldest_pend #(
    .DEPTH (DEPTH)
  ) u_oldest_pend (
    .pend_i  (pend_vec),
    .head_i  (head_q),
    .found_o (pend_found),
    .idx_o   (pend_idx)
  );

  // A presented but unaccepted request is pinned so its fields stay stable
  // even if an older entry is nacked back to pending meanwhile.
  assign sel_idx = hold_q ? issue_q : pend_idx;
  assign sel_vld = hold_q | pend_found;

  assign req_ready_o      = (ent_q[tail_q].state == StFree) & ~drain_q & ~kill_i;
  assign dmem_req_valid_o = sel_vld & ~kill_i;
  assign resp_valid_o     = (ent_q[head_q].state == StDone) & ~drain_q & ~kill_i;

  assign alloc    = req_valid_i & req_ready_o;
  assign issue_hs = dmem_req_valid_o & dmem_req_ready_i;
  assign retire   = resp_valid_o & resp_ready_i;

  // Tags with nonzero upper bits never name a tracker entry.
  assign tag_ok   = ((dmem_resp_tag_i >> IdxW) == '0);
  assign resp_idx = dmem_resp_tag_i[IdxW-1:0];
  assign resp_hit = dmem_resp_valid_i & tag_ok;
  assign nack_hit = dmem_resp_nack_i & tag_ok & ~dmem_resp_valid_i;

  assign dmem_req_cmd_o  = cmd_of(ent_q[sel_idx].is_store);
  assign dmem_req_addr_o = addr_q[sel_idx];
  assign dmem_req_data_o = wdata_q[sel_idx];
  assign dmem_op_type_o  = ent_q[sel_idx].op_type;
  assign dmem_req_tag_o  = TAG_W'(sel_idx);
  assign dmem_req_kill_o = kill_pulse_q;

  assign resp_data_o = rdata_q[head_q];
  assign resp_rd_o   = ent_q[head_q].rd;
  assign resp_xcpt_o = ent_q[head_q].xcpt;

  assign dmem_is_load_o  = is_load_q;
  assign dmem_is_store_o = is_store_q;

  always_comb begin
    ent_d   = ent_q;
    rdata_d = rdata_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc && tail_q == IdxW'(i)) begin
        ent_d[i].state    = StPend;
        ent_d[i].is_store = req_is_store_i;
        ent_d[i].op_type  = req_op_type_i;
        ent_d[i].rd       = req_rd_i;
        ent_d[i].xcpt     = 1'b0;
      end
      if (issue_hs && sel_idx == IdxW'(i)) begin
        ent_d[i].state = StIssued;
      end
      if (retire && head_q == IdxW'(i)) begin
        ent_d[i].state = StFree;
      end
      if (resp_hit && resp_idx == IdxW'(i)) begin
        if (ent_q[i].state == StIssued) begin
          ent_d[i].state = StDone;
          ent_d[i].xcpt  = dmem_xcpt_i;
          rdata_d[i]     = ent_q[i].is_store ? '0 : dmem_resp_data_i;
        end else if (ent_q[i].state == StZombie) begin
          ent_d[i].state = StFree;
        end
      end else if (nack_hit && resp_idx == IdxW'(i)) begin
        if (ent_q[i].state == StIssued) begin
          ent_d[i].state = StPend;
        end else if (ent_q[i].state == StZombie) begin
          ent_d[i].state = StFree;
        end
      end
      // Requests the cache already holds must be drained as zombies.
      if (kill_i) begin
        ent_d[i].state = (ent_d[i].state == StIssued || ent_d[i].state == StZombie) ?
                         StZombie : StFree;
      end
    end
  end

  always_comb begin
    zombie_any = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      zombie_any = zombie_any | (ent_d[i].state == StZombie);
    end
  end

  always_comb begin
    head_d  = head_q + IdxW'(retire);
    tail_d  = tail_q + IdxW'(alloc);
    hold_d  = dmem_req_valid_o & ~dmem_req_ready_i;
    issue_d = hold_d ? sel_idx : issue_q;
    drain_d = zombie_any;
    if ((kill_i || drain_q) && !zombie_any) begin
      head_d  = '0;
      tail_d  = '0;
      issue_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '{state: StFree, default: '0};
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      issue_q      <= '0;
      hold_q       <= 1'b0;
      drain_q      <= 1'b0;
      kill_pulse_q <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      rdata_q <= rdata_d;
      if (alloc) begin
        addr_q[tail_q]  <= req_addr_i;
        wdata_q[tail_q] <= req_data_i;
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      issue_q      <= issue_d;
      hold_q       <= hold_d;
      drain_q      <= drain_d;
      kill_pulse_q <= kill_i;
      is_load_q    <= issue_hs & ~ent_q[sel_idx].is_store;
      is_store_q   <= issue_hs & ent_q[sel_idx].is_store;
    end
  end

  held_entry_pending: assert property (@(posedge clk_i) disable iff (!rstn_i)
    hold_q |-> ent_q[issue_q].state == StPend);

endmodule

// File: tb/tb_dcache_req_tracker.sv
// Randomized bench: a queue-based program-order model plus a toy cache that
// answers, nacks and kills at random; every DUT output is checked each cycle.
module tb_dcache_req_tracker;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 40;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;
  localparam int NCYC   = 5000;
  localparam int RSTCYC = 2500;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_is_store_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic [3:0]        req_op_type_i;
  logic [4:0]        req_rd_i;
  logic              kill_i;
  logic              dmem_req_valid_o;
  logic              dmem_req_ready_i;
  logic [4:0]        dmem_req_cmd_o;
  logic [ADDR_W-1:0] dmem_req_addr_o;
  logic [DATA_W-1:0] dmem_req_data_o;
  logic [3:0]        dmem_op_type_o;
  logic [TAG_W-1:0]  dmem_req_tag_o;
  logic              dmem_req_kill_o;
  logic              dmem_resp_valid_i;
  logic              dmem_resp_nack_i;
  logic [TAG_W-1:0]  dmem_resp_tag_i;
  logic [DATA_W-1:0] dmem_resp_data_i;
  logic              dmem_xcpt_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_data_o;
  logic [4:0]        resp_rd_o;
  logic              resp_xcpt_o;
  logic              dmem_is_load_o;
  logic              dmem_is_store_o;

  always #5 clk_i = ~clk_i;

  dcache_req_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_is_store_i    (req_is_store_i),
    .req_addr_i        (req_addr_i),
    .req_data_i        (req_data_i),
    .req_op_type_i     (req_op_type_i),
    .req_rd_i          (req_rd_i),
    .kill_i            (kill_i),
    .dmem_req_valid_o  (dmem_req_valid_o),
    .dmem_req_ready_i  (dmem_req_ready_i),
    .dmem_req_cmd_o    (dmem_req_cmd_o),
    .dmem_req_addr_o   (dmem_req_addr_o),
    .dmem_req_data_o   (dmem_req_data_o),
    .dmem_op_type_o    (dmem_op_type_o),
    .dmem_req_tag_o    (dmem_req_tag_o),
    .dmem_req_kill_o   (dmem_req_kill_o),
    .dmem_resp_valid_i (dmem_resp_valid_i),
    .dmem_resp_nack_i  (dmem_resp_nack_i),
    .dmem_resp_tag_i   (dmem_resp_tag_i),
    .dmem_resp_data_i  (dmem_resp_data_i),
    .dmem_xcpt_i       (dmem_xcpt_i),
    .resp_valid_o      (resp_valid_o),
    .resp_ready_i      (resp_ready_i),
    .resp_data_o       (resp_data_o),
    .resp_rd_o         (resp_rd_o),
    .resp_xcpt_o       (resp_xcpt_o),
    .dmem_is_load_o    (dmem_is_load_o),
    .dmem_is_store_o   (dmem_is_store_o)
  );

  // st: 0 waiting to issue, 1 at the cache, 2 completed
  typedef struct {
    int                tag;
    bit                is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        op;
    logic [4:0]        rd;
    int                st;
    logic [DATA_W-1:0] rdata;
    bit                xcpt;
  } ent_t;

  ent_t mq[$];
  int   outst[$];
  int   zomb[$];
  int   next_tag;
  bit   held_v;
  int   held_tag;
  bit   exp_kill, exp_ld, exp_st;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_tag(input int t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  task automatic idle_inputs();
    req_valid_i       = 1'b0;
    req_is_store_i    = 1'b0;
    req_addr_i        = '0;
    req_data_i        = '0;
    req_op_type_i     = '0;
    req_rd_i          = '0;
    kill_i            = 1'b0;
    dmem_req_ready_i  = 1'b0;
    dmem_resp_valid_i = 1'b0;
    dmem_resp_nack_i  = 1'b0;
    dmem_resp_tag_i   = '0;
    dmem_resp_data_i  = '0;
    dmem_xcpt_i       = 1'b0;
    resp_ready_i      = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    outst.delete();
    zomb.delete();
    next_tag = 0;
    held_v   = 0;
    held_tag = 0;
    exp_kill = 0;
    exp_ld   = 0;
    exp_st   = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", req_ready_o, 1);
    check_eq("rst_dmem_valid", dmem_req_valid_o, 0);
    check_eq("rst_dmem_cmd", dmem_req_cmd_o, 0);
    check_eq("rst_dmem_addr", dmem_req_addr_o, 0);
    check_eq("rst_dmem_data", dmem_req_data_o, 0);
    check_eq("rst_dmem_op", dmem_op_type_o, 0);
    check_eq("rst_dmem_tag", dmem_req_tag_o, 0);
    check_eq("rst_dmem_kill", dmem_req_kill_o, 0);
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_resp_data", resp_data_o, 0);
    check_eq("rst_resp_rd", resp_rd_o, 0);
    check_eq("rst_resp_xcpt", resp_xcpt_o, 0);
    check_eq("rst_pmu_ld", dmem_is_load_o, 0);
    check_eq("rst_pmu_st", dmem_is_store_o, 0);
  endtask

  task automatic drive_random();
    logic [63:0] r64;
    int k, r;
    req_valid_i    = ($urandom_range(9) < 6);
    req_is_store_i = $urandom_range(1);
    r64            = {$urandom(), $urandom()};
    req_addr_i     = r64[ADDR_W-1:0];
    req_data_i     = {$urandom(), $urandom()};
    req_op_type_i  = 4'($urandom_range(15));
    req_rd_i       = 5'($urandom_range(31));
    kill_i         = ($urandom_range(99) < 3);
    dmem_req_ready_i  = ($urandom_range(9) < 7);
    dmem_resp_valid_i = 1'b0;
    dmem_resp_nack_i  = 1'b0;
    dmem_resp_tag_i   = '0;
    dmem_resp_data_i  = {$urandom(), $urandom()};
    dmem_xcpt_i       = ($urandom_range(9) == 0);
    if (outst.size() > 0 && $urandom_range(9) < 4) begin
      k = $urandom_range(outst.size() - 1);
      r = $urandom_range(9);
      dmem_resp_tag_i   = TAG_W'(outst[k]);
      dmem_resp_valid_i = (r < 7) || (r == 9);
      dmem_resp_nack_i  = (r >= 7);
    end
    resp_ready_i = ($urandom_range(9) < 7);
  endtask

  task automatic step();
    bit draining, exp_rdy, exp_dv, exp_rv;
    int pi, ei, t, zi, ri;
    draining = (zomb.size() != 0);
    exp_rdy  = (mq.size() < DEPTH) && !draining && !kill_i;
    pi = -1;
    foreach (mq[i]) if (pi < 0 && mq[i].st == 0) pi = i;
    exp_dv  = (held_v || pi >= 0) && !kill_i;
    ei      = -1;
    if (exp_dv) ei = held_v ? find_tag(held_tag) : pi;
    exp_rv = (mq.size() > 0) && (mq[0].st == 2) && !kill_i && !draining;

    check_eq("req_ready", req_ready_o, exp_rdy);
    check_eq("dmem_valid", dmem_req_valid_o, exp_dv);
    if (exp_dv) begin
      check_eq("dmem_tag", dmem_req_tag_o, 64'(mq[ei].tag));
      check_eq("dmem_cmd", dmem_req_cmd_o, mq[ei].is_store ? 64'd1 : 64'd0);
      check_eq("dmem_addr", dmem_req_addr_o, 64'(mq[ei].addr));
      check_eq("dmem_data", dmem_req_data_o, mq[ei].wdata);
      check_eq("dmem_op", dmem_op_type_o, 64'(mq[ei].op));
    end
    check_eq("resp_valid", resp_valid_o, exp_rv);
    if (exp_rv) begin
      check_eq("resp_rd", resp_rd_o, 64'(mq[0].rd));
      check_eq("resp_data", resp_data_o, mq[0].rdata);
      check_eq("resp_xcpt", resp_xcpt_o, 64'(mq[0].xcpt));
    end
    check_eq("dmem_kill", dmem_req_kill_o, exp_kill);
    check_eq("pmu_ld", dmem_is_load_o, exp_ld);
    check_eq("pmu_st", dmem_is_store_o, exp_st);

    // Advance the model across the coming clock edge.
    exp_kill = kill_i;
    exp_ld   = exp_dv && dmem_req_ready_i && !mq[ei].is_store;
    exp_st   = exp_dv && dmem_req_ready_i && mq[ei].is_store;
    held_v   = exp_dv && !dmem_req_ready_i;
    if (exp_dv) held_tag = mq[ei].tag;
    if (exp_dv && dmem_req_ready_i) begin
      mq[ei].st = 1;
      outst.push_back(mq[ei].tag);
    end
    if (exp_rv && resp_ready_i) void'(mq.pop_front());
    if (exp_rdy && req_valid_i) begin
      mq.push_back('{tag: next_tag, is_store: req_is_store_i, addr: req_addr_i,
                     wdata: req_data_i, op: req_op_type_i, rd: req_rd_i, st: 0,
                     rdata: '0, xcpt: 1'b0});
      next_tag = (next_tag + 1) % DEPTH;
    end
    if (dmem_resp_valid_i || dmem_resp_nack_i) begin
      t = int'(dmem_resp_tag_i);
      foreach (outst[i]) if (outst[i] == t) begin outst.delete(i); break; end
      zi = -1;
      foreach (zomb[i]) if (zomb[i] == t) zi = i;
      if (zi >= 0) begin
        zomb.delete(zi);
      end else begin
        ri = find_tag(t);
        if (ri >= 0 && mq[ri].st == 1) begin
          if (dmem_resp_valid_i) begin
            mq[ri].st    = 2;
            mq[ri].rdata = mq[ri].is_store ? 64'd0 : dmem_resp_data_i;
            mq[ri].xcpt  = dmem_xcpt_i;
          end else begin
            mq[ri].st = 0;
          end
        end
      end
    end
    if (kill_i) begin
      zomb = outst;
      mq.delete();
      held_v = 0;
    end
    if ((kill_i || draining) && zomb.size() == 0) next_tag = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check_reset_outputs();
    rstn_i = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk_i);
      if (cyc == RSTCYC) begin
        // Asynchronous reset mid-traffic: outputs must clear without a clock.
        idle_inputs();
        rstn_i = 1'b0;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge clk_i);
        rstn_i = 1'b1;
        continue;
      end
      drive_random();
      #1;
      step();
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_req_tracker.md
Name: dcache_req_tracker

Overview:
Parametrised successor to the single-request data cache interface. Holds up to DEPTH CPU memory requests in a circular tracking buffer and issues them to the data cache with per-entry tags. Entries nacked by the cache are replayed, and completions are returned to writeback in program order. Sits between the memory pipeline stage and the data cache; it also drives the PMU load/store event pulses.

Parameters:
DEPTH, 4, tracked entries; power of 2, range 2..16
ADDR_W, 40, address width
DATA_W, 64, data width
TAG_W, 8, cache tag width; low log2(DEPTH) bits carry the entry index, upper bits are zero

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_valid_i  in  1  CPU request valid
req_ready_o  out  1  tracker can accept a request
req_is_store_i  in  1  1 = store, 0 = load
req_addr_i  in  ADDR_W  access address
req_data_i  in  DATA_W  store data
req_op_type_i  in  4  access granularity
req_rd_i  in  5  destination register
kill_i  in  1  flush all requests
dmem_req_valid_o  out  1  request to cache valid
dmem_req_ready_i  in  1  cache accepts request
dmem_req_cmd_o  out  5  5'b00000 load, 5'b00001 store
dmem_req_addr_o  out  ADDR_W  address
dmem_req_data_o  out  DATA_W  store data
dmem_op_type_o  out  4  granularity
dmem_req_tag_o  out  TAG_W  entry tag
dmem_req_kill_o  out  1  one-cycle kill pulse to cache
dmem_resp_valid_i  in  1  response valid
dmem_resp_nack_i  in  1  request with dmem_resp_tag_i was refused
dmem_resp_tag_i  in  TAG_W  tag of response or nack
dmem_resp_data_i  in  DATA_W  load data
dmem_xcpt_i  in  1  exception (misaligned or page fault), qualified by dmem_resp_valid_i
resp_valid_o  out  1  in-order completion valid
resp_ready_i  in  1  writeback accepts completion
resp_data_o  out  DATA_W  load data (0 for stores)
resp_rd_o  out  5  destination register
resp_xcpt_o  out  1  exception flag
dmem_is_load_o  out  1  PMU pulse: load accepted by cache
dmem_is_store_o  out  1  PMU pulse: store accepted by cache

Behaviour:
- Reset: all entries FREE; head, tail and issue pointers 0; drain flag 0; every output 0 except req_ready_o = 1 (no drain after reset).
- Entry states: FREE -> PEND (alloc) -> ISSUED (dmem handshake) -> DONE (resp_valid) -> FREE (retire). ISSUED -> PEND on nack.
- req_ready_o = (tail entry FREE) && !drain && !kill_i. A handshake writes the tail entry and increments tail modulo DEPTH.
- Issue selects the oldest PEND entry, searching from head. dmem_req_* come from registered entry state: a request accepted in cycle N is presented no earlier than cycle N+1. dmem_req_valid_o holds with stable fields until dmem_req_ready_i.
- A nack moves the tagged entry back to PEND. It reissues no earlier than 1 cycle later and stays older than any younger PEND entry.
- dmem_resp_valid_i with tag t latches data and xcpt into entry t and sets it DONE. Store completion is signalled the same way.
- Retire: resp_valid_o = (head entry DONE), combinational from entry state. When resp_ready_i is high, the entry goes FREE and head increments. A response arriving in cycle M can therefore retire at M+1 at the earliest.
- Same-cycle events:
  - Alloc and retire on the same entry index is impossible (full vs. empty disambiguated by state).
  - Alloc and retire in the same cycle: both occur.
  - Response and nack for the same tag: nack ignored, response wins.
- kill_i:
  - All PEND and DONE entries go FREE.
  - ISSUED entries become ZOMBIE; dmem_req_kill_o pulses for 1 cycle; drain = 1.
  - A ZOMBIE goes FREE on its response or nack, and its data is discarded.
  - When no ZOMBIE remains, head/tail/issue reset to 0 and drain clears.
  - resp_valid_o is 0 during the kill cycle and the drain.
- dmem_is_load_o / dmem_is_store_o pulse 1 cycle after each dmem handshake.
- Full: DEPTH non-FREE entries means req_ready_o = 0. Empty: no dmem_req_valid_o and no resp_valid_o.

Decomposition:
- Shared package (drac_pkg): tracker_state_t enum (FREE, PEND, ISSUED, DONE, ZOMBIE), tracker_entry_t struct, and cmd constants for load and store.
- Sub-module tracker_oldest_pend: a combinational priority finder that rotates from head and outputs the oldest PEND index plus a found bit.

Test Plan:
- Load to 0x1000 (rd=5) is accepted; cache returns tag 0 with data 0xDEAD two cycles later -> dmem_req_tag_o=0 and dmem_is_load_o pulses; resp_valid_o one cycle after the response with resp_data_o=0xDEAD, resp_rd_o=5.
- Issue 4 loads (DEPTH=4) -> req_ready_o=0 after the 4th; responses arrive in order 3,1,0,2 -> retire order 0,1,2,3 with the correct data.
- Tag 1 is nacked -> entry 1 reissues before entry 2 is issued, still carrying tag 1, and completes normally.
- Entries 0 and 1 ISSUED, entry 2 PEND when kill_i=1 -> dmem_req_kill_o pulses, req_ready_o=0; late responses for tags 0 and 1 produce no resp_valid_o; req_ready_o returns to 1 after the second response and the next request gets tag 0.
- Store with dmem_xcpt_i=1 on its response -> resp_xcpt_o=1, resp_data_o=0; dmem_is_store_o pulsed at issue.
- rstn_i asserted with 3 entries in flight -> all outputs at reset values immediately; after release, req_ready_o=1 and the next request gets tag 0.
